// File: rtl/stage_mem_lsu_if.sv
// stage_mem_lsu_if: Wishbone classic data-side bus between the LSU (master) and memory (slave).
interface stage_mem_lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              cyc;
  logic              stb;
  logic              we;
  logic [XLEN/8-1:0] sel;
  logic [XLEN-1:0]   dat_o;
  logic [ADDR_W-1:0] addr;
  logic [XLEN-1:0]   dat_i;
  logic              ack;
  logic              err;
  modport master (output cyc, stb, we, sel, dat_o, addr, input dat_i, ack, err);
  modport slave  (input cyc, stb, we, sel, dat_o, addr, output dat_i, ack, err);
endinterface

// File: rtl/stage_mem_lsu.sv
// stage_mem_lsu: registered memory-stage load/store unit driving a Wishbone classic master.
module stage_mem_lsu #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [2:0]           funct3_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [XLEN-1:0]      st_data_i,
  input  logic                 kill_i,
  output logic                 stall_o,
  output logic                 done_o,
  output logic [XLEN-1:0]      ld_data_o,
  output logic                 e_ld_addr_mis_o,
  output logic                 e_st_addr_mis_o,
  output logic                 e_ld_access_o,
  output logic                 e_st_access_o,
  output logic [ADDR_W-1:0]    fault_addr_o,
  stage_mem_lsu_if.master      wbm
);
  localparam int SW  = XLEN / 8;
  localparam int OFF = $clog2(SW);
  localparam int CW  = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  state_t          state;
  logic [OFF-1:0]  lane, lane_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [CW-1:0]   cnt;
  logic            mis, tmo, fault, sgn;
  logic [SW-1:0]   mask;
  logic [XLEN-1:0] rep, sh, lowm, fmt;
  assign stall_o = req_i & ~done_o;
  always_comb begin
    lane = addr_i[OFF-1:0];
    mis  = funct3_i[1:0] == 2'b01 ? addr_i[0] :
           funct3_i[1:0] == 2'b10 ? |addr_i[1:0] :
           funct3_i[1:0] == 2'b11 ? (XLEN == 32) || (|addr_i[2:0]) : 1'b0;
    mask = funct3_i[1:0] == 2'b00 ? SW'(8'h01) :
           funct3_i[1:0] == 2'b01 ? SW'(8'h03) :
           funct3_i[1:0] == 2'b10 ? SW'(8'h0F) : SW'(8'hFF);
    rep  = funct3_i[1:0] == 2'b00 ? {SW{st_data_i[7:0]}} :
           funct3_i[1:0] == 2'b01 ? {(SW/2){st_data_i[15:0]}} :
           funct3_i[1:0] == 2'b10 ? {(XLEN/32){st_data_i[31:0]}} : st_data_i;
    // load formatting: shift the addressed lane down, then mask and sign-fill above the access size
    sh   = wbm.dat_i >> {lane_q, 3'b000};
    lowm = size_q == 2'b00 ? XLEN'(8'hFF) :
           size_q == 2'b01 ? XLEN'(16'hFFFF) :
           size_q == 2'b10 ? XLEN'(32'hFFFF_FFFF) : {XLEN{1'b1}};
    sgn  = ~uns_q & (size_q == 2'b00 ? sh[7] : size_q == 2'b01 ? sh[15] :
                     size_q == 2'b10 ? sh[31] : sh[XLEN-1]);
    fmt  = (sh & lowm) | (~lowm & {XLEN{sgn}});
    tmo  = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
    fault = wbm.err | (tmo & ~wbm.ack);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state           <= IDLE;
      wbm.cyc         <= 1'b0;
      wbm.stb         <= 1'b0;
      wbm.we          <= 1'b0;
      wbm.sel         <= '0;
      wbm.dat_o       <= '0;
      wbm.addr        <= '0;
      done_o          <= 1'b0;
      ld_data_o       <= '0;
      e_ld_addr_mis_o <= 1'b0;
      e_st_addr_mis_o <= 1'b0;
      e_ld_access_o   <= 1'b0;
      e_st_access_o   <= 1'b0;
      fault_addr_o    <= '0;
      cnt             <= '0;
      lane_q          <= '0;
      size_q          <= '0;
      uns_q           <= 1'b0;
    end else if (kill_i) begin
      state           <= IDLE;
      wbm.cyc         <= 1'b0;
      wbm.stb         <= 1'b0;
      wbm.we          <= 1'b0;
      done_o          <= 1'b0;
      e_ld_addr_mis_o <= 1'b0;
      e_st_addr_mis_o <= 1'b0;
      e_ld_access_o   <= 1'b0;
      e_st_access_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_i) begin
          fault_addr_o <= addr_i;
          if (mis) begin
            state           <= DONE;
            done_o          <= 1'b1;
            e_ld_addr_mis_o <= ~we_i;
            e_st_addr_mis_o <= we_i;
          end else begin
            state     <= BUS;
            wbm.cyc   <= 1'b1;
            wbm.stb   <= 1'b1;
            wbm.we    <= we_i;
            wbm.sel   <= mask << lane;
            wbm.dat_o <= rep;
            wbm.addr  <= addr_i & ~ADDR_W'(SW - 1);
            lane_q    <= lane;
            size_q    <= funct3_i[1:0];
            uns_q     <= funct3_i[2];
            cnt       <= '0;
          end
        end
        BUS: if (fault | wbm.ack) begin
          state         <= DONE;
          done_o        <= 1'b1;
          wbm.cyc       <= 1'b0;
          wbm.stb       <= 1'b0;
          wbm.we        <= 1'b0;
          e_ld_access_o <= fault & ~wbm.we;
          e_st_access_o <= fault & wbm.we;
          if (!fault && !wbm.we) ld_data_o <= fmt;
        end else begin
          cnt <= cnt + 1'b1;
        end
        DONE: begin
          state           <= IDLE;
          done_o          <= 1'b0;
          e_ld_addr_mis_o <= 1'b0;
          e_st_addr_mis_o <= 1'b0;
          e_ld_access_o   <= 1'b0;
          e_st_access_o   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stage_mem_lsu.sv
// tb_stage_mem_lsu: table-driven scoreboard bench for a 32-bit (TIMEOUT=4) and a 64-bit LSU.
module tb_stage_mem_lsu;
  typedef struct {
    bit        is64;
    bit        we;
    bit [2:0]  f3;
    bit [31:0] addr;
    bit [63:0] st;
    bit [63:0] rdat;
    int        waits;
    bit [1:0]  rsp;
    bit [7:0]  sel;
    bit [31:0] baddr;
    bit [63:0] bdat;
    bit [63:0] ld;
    bit        mis;
    bit        acc;
    int        lat;
    int        ncyc;
  } vec_t;
  logic clk = 0, rst_n = 0, req = 0, we = 0, kill = 0, is64 = 0, ack = 0, err = 0;
  logic [2:0]  f3 = 0;
  logic [31:0] addr = 0;
  logic [63:0] st = 0, rdat = 0;
  int checks = 0, errors = 0;
  vec_t vt[$];
  vec_t sb[$];
  always #5 clk = ~clk;
  stage_mem_lsu_if #(.XLEN(32), .ADDR_W(32)) b32();
  stage_mem_lsu_if #(.XLEN(64), .ADDR_W(32)) b64();
  logic stall32, done32, lm32, sm32, la32, sa32, stall64, done64, lm64, sm64, la64, sa64;
  logic [31:0] ld32, fa32, fa64;
  logic [63:0] ld64;
  assign b32.dat_i = rdat[31:0];
  assign b32.ack   = ack & ~is64;
  assign b32.err   = err & ~is64;
  assign b64.dat_i = rdat;
  assign b64.ack   = ack & is64;
  assign b64.err   = err & is64;
  stage_mem_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) u32 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req & ~is64), .we_i(we), .funct3_i(f3), .addr_i(addr),
    .st_data_i(st[31:0]), .kill_i(kill & ~is64), .stall_o(stall32), .done_o(done32), .ld_data_o(ld32),
    .e_ld_addr_mis_o(lm32), .e_st_addr_mis_o(sm32), .e_ld_access_o(la32), .e_st_access_o(sa32),
    .fault_addr_o(fa32), .wbm(b32));
  stage_mem_lsu #(.XLEN(64), .ADDR_W(32)) u64 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req & is64), .we_i(we), .funct3_i(f3), .addr_i(addr),
    .st_data_i(st), .kill_i(kill & is64), .stall_o(stall64), .done_o(done64), .ld_data_o(ld64),
    .e_ld_addr_mis_o(lm64), .e_st_addr_mis_o(sm64), .e_ld_access_o(la64), .e_st_access_o(sa64),
    .fault_addr_o(fa64), .wbm(b64));
  logic v_cyc, v_stb, v_we, v_done, v_stall;
  logic [3:0]  v_flags;
  logic [7:0]  v_sel;
  logic [31:0] v_addr, v_fa;
  logic [63:0] v_dat, v_ld;
  always_comb begin
    v_cyc   = is64 ? b64.cyc : b32.cyc;
    v_stb   = is64 ? b64.stb : b32.stb;
    v_we    = is64 ? b64.we : b32.we;
    v_done  = is64 ? done64 : done32;
    v_stall = is64 ? stall64 : stall32;
    v_flags = is64 ? {lm64, sm64, la64, sa64} : {lm32, sm32, la32, sa32};
    v_sel   = is64 ? b64.sel : {4'b0, b32.sel};
    v_addr  = is64 ? b64.addr : b32.addr;
    v_fa    = is64 ? fa64 : fa32;
    v_dat   = is64 ? b64.dat_o : {32'b0, b32.dat_o};
    v_ld    = is64 ? ld64 : {32'b0, ld32};
  end
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  function automatic vec_t mk(bit x64, bit w, bit [2:0] f, bit [31:0] a, bit [63:0] s, bit [63:0] r,
                              int wt, bit [1:0] rp, bit [7:0] sl, bit [31:0] ba, bit [63:0] bd,
                              bit [63:0] l, bit m, bit ac, int lt, int nc);
    vec_t v;
    v.is64 = x64; v.we = w; v.f3 = f; v.addr = a; v.st = s; v.rdat = r; v.waits = wt; v.rsp = rp;
    v.sel = sl; v.baddr = ba; v.bdat = bd; v.ld = l; v.mis = m; v.acc = ac; v.lat = lt; v.ncyc = nc;
    return v;
  endfunction
  task automatic run(input vec_t v);
    vec_t e;
    int cyc_n = 0;
    bit fin = 0;
    @(negedge clk);
    is64 = v.is64; we = v.we; f3 = v.f3; addr = v.addr; st = v.st; rdat = v.rdat;
    sb.push_back(v);
    req = 1;
    #1 chk("stall_req", v_stall, 1);
    for (int c = 1; c <= 40 && !fin; c++) begin
      @(posedge clk);
      #1;
      if (v_cyc) begin
        cyc_n++;
        if (cyc_n == 1) begin
          chk("bus_sel", v_sel, v.sel);
          chk("bus_addr", v_addr, v.baddr);
          chk("bus_dat", v_dat, v.bdat);
          chk("bus_we_stb", {v_we, v_stb}, {v.we, 1'b1});
        end
      end
      ack = v_cyc && cyc_n > v.waits && v.rsp[0];
      err = v_cyc && cyc_n > v.waits && v.rsp[1];
      if (v_done) begin
        fin = 1;
        e = sb.pop_front();
        chk("latency", c, e.lat);
        chk("cyc_cycles", cyc_n, e.ncyc);
        chk("ld_data", v_ld, e.ld);
        chk("flags", v_flags, {e.mis & ~e.we, e.mis & e.we, e.acc & ~e.we, e.acc & e.we});
        chk("stall_done", v_stall, 0);
        if (e.mis || e.acc) chk("fault_addr", v_fa, e.addr);
      end
    end
    chk("done_seen", fin, 1);
    @(negedge clk);
    req = 0; ack = 0; err = 0;
  endtask
  task automatic start_and_hold(input bit x64, input bit [31:0] a);
    @(negedge clk);
    is64 = x64; we = 0; f3 = 3'b010; addr = a; rdat = 0; req = 1;
    repeat (2) @(posedge clk);
    #1 chk("abort_pre_cyc", v_cyc, 1);
  endtask
  task automatic quiet(input string n);
    bit seen = 0;
    repeat (4) begin
      @(posedge clk);
      #1 seen |= v_done | v_cyc;
    end
    chk(n, seen, 0);
  endtask
  initial begin
    vt.push_back(mk(0,0,3'b000,32'h1003,0,64'h80FF1234,0,1,8'h08,32'h1000,0,64'hFFFFFF80,0,0,2,1));
    vt.push_back(mk(0,0,3'b100,32'h1003,0,64'h80FF1234,0,1,8'h08,32'h1000,0,64'h80,0,0,2,1));
    vt.push_back(mk(0,1,3'b001,32'h2002,64'hABCD,0,3,1,8'h0C,32'h2000,64'hABCDABCD,64'h80,0,0,5,4));
    vt.push_back(mk(0,0,3'b010,32'h3001,0,0,0,1,0,0,0,64'h80,1,0,1,0));
    vt.push_back(mk(0,1,3'b010,32'h4000,64'h11223344,0,0,3,8'h0F,32'h4000,64'h11223344,64'h80,0,1,2,1));
    vt.push_back(mk(0,0,3'b010,32'h5000,0,0,100,0,8'h0F,32'h5000,0,64'h80,0,1,5,4));
    vt.push_back(mk(0,0,3'b001,32'h6002,0,64'h80017FFF,1,1,8'h0C,32'h6000,0,64'hFFFF8001,0,0,3,2));
    vt.push_back(mk(0,0,3'b101,32'h6000,0,64'h80017FFF,0,1,8'h03,32'h6000,0,64'h7FFF,0,0,2,1));
    vt.push_back(mk(0,1,3'b000,32'h7001,64'h5A,0,0,1,8'h02,32'h7000,64'h5A5A5A5A,64'h7FFF,0,0,2,1));
    vt.push_back(mk(0,1,3'b001,32'h7001,64'h1234,0,0,1,0,0,0,64'h7FFF,1,0,1,0));
    vt.push_back(mk(0,0,3'b011,32'h8000,0,0,0,1,0,0,0,64'h7FFF,1,0,1,0));
    vt.push_back(mk(1,0,3'b011,32'h0008,0,64'h0123456789ABCDEF,0,1,8'hFF,32'h8,0,64'h0123456789ABCDEF,0,0,2,1));
    vt.push_back(mk(1,0,3'b010,32'h000C,0,64'h80000001DEADBEEF,0,1,8'hF0,32'h8,0,64'hFFFFFFFF80000001,0,0,2,1));
    vt.push_back(mk(1,0,3'b110,32'h000C,0,64'h80000001DEADBEEF,0,1,8'hF0,32'h8,0,64'h80000001,0,0,2,1));
    vt.push_back(mk(1,1,3'b010,32'h0014,64'hCAFEBABE,0,0,1,8'hF0,32'h10,64'hCAFEBABECAFEBABE,64'h80000001,0,0,2,1));
    vt.push_back(mk(1,0,3'b011,32'h0004,0,0,0,1,0,0,0,64'h80000001,1,0,1,0));
    vt.push_back(mk(1,0,3'b100,32'h001F,0,64'hA500000000000000,0,1,8'h80,32'h18,0,64'hA5,0,0,2,1));
    repeat (2) @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      is64 = i[0];
      #1;
      chk("rst_bus", {v_cyc, v_stb, v_we, v_sel, v_addr}, 0);
      chk("rst_out", {v_done, v_flags, v_fa, v_dat}, 0);
      chk("rst_ld", v_ld, 0);
    end
    @(negedge clk);
    rst_n = 1;
    foreach (vt[i]) run(vt[i]);
    start_and_hold(0, 32'h9000);
    @(negedge clk);
    kill = 1;
    @(posedge clk);
    #1 chk("kill_drop", {v_cyc, v_stb, v_done}, 0);
    @(negedge clk);
    kill = 0; req = 0;
    quiet("kill_no_done");
    run(mk(0,0,3'b100,32'h1003,0,64'h80FF1234,0,1,8'h08,32'h1000,0,64'h80,0,0,2,1));
    start_and_hold(0, 32'hA000);
    @(negedge clk);
    rst_n = 0;
    @(posedge clk);
    #1 chk("rst_mid_drop", {v_cyc, v_stb, v_done}, 0);
    chk("rst_mid_ld", v_ld, 0);
    @(negedge clk);
    rst_n = 1; req = 0;
    quiet("rst_no_done");
    run(mk(0,0,3'b000,32'h1003,0,64'h80FF1234,0,1,8'h08,32'h1000,0,64'hFFFFFF80,0,0,2,1));
    start_and_hold(1, 32'h40);
    @(negedge clk);
    kill = 1;
    @(posedge clk);
    #1 chk("kill64_drop", {v_cyc, v_stb, v_done}, 0);
    @(negedge clk);
    kill = 0; req = 0;
    @(negedge clk);
    is64 = 0; addr = 32'h1000; f3 = 3'b000; req = 1; kill = 1;
    @(posedge clk);
    #1 chk("kill_idle_req", {v_cyc, v_done}, 0);
    @(negedge clk);
    kill = 0; req = 0;
    quiet("kill_idle_quiet");
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stage_mem_lsu.md
Name: stage_mem_lsu

Overview:
Parametrised, registered load/store unit for the memory stage: it replaces the combinational LSU/WBU pairing with a single FSM-driven Wishbone classic master. It supports XLEN 32 or 64 with byte-lane steering, sign/zero extension, misalignment and access-fault exceptions, bus timeout, kill/abort and a pipeline stall output. It sits between the execute/memory pipeline register and the data-side Wishbone bus.

Parameters:
XLEN, 32, data width (32 or 64); sel width is XLEN/8.
ADDR_W, 32, bus address width.
TIMEOUT, 255, cycles in BUS before access fault is forced; 0 disables the timeout.

Ports:
clk_i  in  1  clock; all state updates on rising edge.
rst_i  in  1  one clock; reset is synchronous and active-low.
req_i  in  1  memory op request; held with operands stable until done_o.
we_i  in  1  1 = store, 0 = load.
funct3_i  in  3  RISC-V width/sign code.
addr_i  in  ADDR_W  effective address.
st_data_i  in  XLEN  store data, LSB-justified.
kill_i  in  1  abort current op (trap/flush).
stall_o  out  1  req_i & ~done_o.
done_o  out  1  one-cycle completion pulse.
ld_data_o  out  XLEN  formatted load data, valid when done_o.
e_ld_addr_mis_o, e_st_addr_mis_o  out  1 each  misaligned load/store, valid with done_o.
e_ld_access_o, e_st_access_o  out  1 each  bus error/timeout, valid with done_o.
fault_addr_o  out  ADDR_W  addr of faulting op (mtval), valid with any exception.
wbm_dat_i  in  XLEN; wbm_ack_i, wbm_err_i  in  1.
wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1; wbm_sel_o  out  XLEN/8; wbm_dat_o  out  XLEN; wbm_addr_o  out  ADDR_W.

Behaviour:
- Reset (rst_i=0 at edge): state IDLE; cyc/stb/we/done_o and all exception outputs 0; sel, dat_o, addr_o, ld_data_o, fault_addr_o, timeout counter all 0. Applies mid-transaction: cyc/stb drop at that edge, no done_o.
- FSM states IDLE, BUS, DONE. req_i is sampled only in IDLE.
- Size from funct3_i[1:0]: 00 byte, 01 half, 10 word, 11 double (legal only when XLEN=64; with XLEN=32 it is treated as misaligned). funct3_i[2] = zero-extend.
- Misaligned: half with addr[0]≠0; word with addr[1:0]≠0; double with addr[2:0]≠0.
- IDLE & req_i & misaligned: go to DONE with the matching e_*_addr_mis_o and fault_addr_o=addr_i; no bus cycle.
- IDLE & req_i & aligned:
  - Go to BUS and register cyc=stb=1 and we=we_i.
  - addr_o = addr_i with low log2(XLEN/8) bits cleared.
  - sel = size mask shifted by lane offset.
  - dat_o = store data replicated into every lane of its size.
  - Bus signals are stable throughout BUS. Latency: cyc high the cycle after the request.
- BUS & ack: latch lane-extracted, sign/zero-extended wbm_dat_i into ld_data_o (loads only; stores leave it unchanged); go to DONE. cyc/stb drop at the same edge.
- BUS & err (err has priority over simultaneous ack): go to DONE with e_ld_access_o/e_st_access_o and fault_addr_o set; cyc/stb drop.
- Timeout: the counter clears on entry to BUS and increments each BUS cycle. If it reaches TIMEOUT with no ack/err, behave as err.
- DONE: done_o=1 for exactly one cycle, exception flags valid with it, then IDLE. Flags clear in IDLE.
- Back-to-back: min 3 cycles per aligned op (IDLE, BUS, DONE) with zero-wait ack; 2 cycles for misaligned ops.
- kill_i: in any state, next state is IDLE. cyc/stb/done_o/flags drop at that edge and no completion is reported. kill_i in IDLE with req_i starts nothing. rst_i overrides kill_i.
- stall_o is combinational; upstream advances only on done_o.

Test Plan:
- XLEN=32, lb from 0x1003, wbm_dat_i=0x80FF_1234 with 0-wait ack -> sel=1000, addr_o=0x1000; done_o 2 cycles after req; ld_data_o=0xFFFF_FF80. Repeat with lbu -> 0x0000_0080.
- sh data 0xABCD to 0x2002, ack after 3 waits -> sel=1100, dat_o=0xABCD_ABCD, we=1; cyc high exactly 4 cycles; done_o pulse with no exception flags.
- lw at 0x3001 -> no cyc ever; done_o one cycle after req; e_ld_addr_mis_o=1, fault_addr_o=0x3001.
- sw at 0x4000 with err and ack asserted together -> e_st_access_o=1, fault_addr_o=0x4000, ld_data_o unchanged. TIMEOUT=4 with no ack -> access fault with done_o on the cycle after the 4th BUS cycle.
- XLEN=64, ld from 0x8 with data 0x0123_4567_89AB_CDEF -> sel=0xFF, ld_data_o equals input. lw from 0xC with data 0x8000_0001_xxxx_xxxx -> 0xFFFF_FFFF_8000_0001.
- kill_i mid-BUS, and separately rst_i=0 mid-BUS -> cyc/stb low next edge, no done_o. A new request afterwards completes normally.
